// File: rtl/pc_pkg.sv
// Shared types and default constants for the PC / trap sequencer.
package pc_pkg;

  typedef enum logic {
    RUN,
    HANDLER
  } state_e;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JAL,
    JALR,
    TRAP,
    TRET,
    HOLD
  } pc_sel_e;

  localparam int DEFAULT_TRAP_VEC = 'h40;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector that emits a single-cycle pulse.
module irq_sync_edge #(
  parameter int IRQ_SYNC = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  // Fewer than two flops gives no metastability protection, so clamp.
  localparam int STAGES = (IRQ_SYNC < 2) ? 2 : IRQ_SYNC;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pc_trap_unit.sv
// Program counter, next-PC mux and single-level trap sequencer with
// synchronised interrupt capture and memory-busy stall.
module pc_trap_unit
  import pc_pkg::*;
#(
  parameter int NBITS       = 8,
  parameter int INSTR_BYTES = 4,
  parameter int RESET_PC    = DEFAULT_RESET_PC,
  parameter int TRAP_VEC    = DEFAULT_TRAP_VEC,
  parameter int IRQ_SYNC    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             busy,
  input  logic             interrupt,
  input  logic             branch,
  input  logic             eflag,
  input  logic             ju,
  input  logic             jr,
  input  logic             tret,
  input  logic [NBITS-1:0] imm,
  input  logic [NBITS-1:0] rs1_val,
  output logic [NBITS-1:0] pc,
  output logic [NBITS-1:0] pc_next,
  output logic             link,
  output logic [NBITS-1:0] pclink,
  output logic [NBITS-1:0] sepc,
  output logic             in_trap,
  output logic             irq_ack
);

  localparam logic [NBITS-1:0] STEP       = NBITS'(INSTR_BYTES);
  localparam logic [NBITS-1:0] TVEC       = NBITS'(TRAP_VEC);
  localparam logic [NBITS-1:0] RPC        = NBITS'(RESET_PC);
  localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'(1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] sepc_q, sepc_d;
  logic             pending_q, pending_d;
  logic             ack_q;

  logic             irqPulse;
  logic             trapEntry;
  pc_sel_e          flowSel, sel;
  logic [NBITS-1:0] pcSeq, pcRel, jalrSum, flowTarget, selTarget;

  irq_sync_edge #(
    .IRQ_SYNC (IRQ_SYNC)
  ) u_irq_sync_edge (
    .clock   (clock),
    .reset   (reset),
    .async_i (interrupt),
    .pulse_o (irqPulse)
  );

  // Program-flow target ignoring traps; this is also what sepc captures on entry.
  always_comb begin
    pcSeq   = pc_q + STEP;
    pcRel   = pc_q + imm;
    jalrSum = rs1_val + imm;

    flowSel = SEQ;
    if (jr) begin
      flowSel = JALR;
    end else if (ju) begin
      flowSel = JAL;
    end else if (branch && eflag) begin
      flowSel = BR;
    end

    case (flowSel)
      JALR:    flowTarget = jalrSum & ALIGN_MASK;
      JAL:     flowTarget = pcRel;
      BR:      flowTarget = pcRel;
      default: flowTarget = pcSeq;
    endcase
  end

  assign trapEntry = !busy && (state_q == RUN) && pending_q;

  always_comb begin
    sel = flowSel;
    if (busy) begin
      sel = HOLD;
    end else if (trapEntry) begin
      sel = TRAP;
    end else if ((state_q == HANDLER) && tret) begin
      sel = TRET;
    end

    case (sel)
      HOLD:    selTarget = pc_q;
      TRAP:    selTarget = TVEC;
      TRET:    selTarget = sepc_q;
      default: selTarget = flowTarget;
    endcase

    pc_d = reset ? RPC : selTarget;
  end

  // A fresh edge in the entry cycle re-arms pending rather than being lost.
  always_comb begin
    state_d   = state_q;
    sepc_d    = sepc_q;
    pending_d = pending_q | irqPulse;
    if (trapEntry) begin
      state_d   = HANDLER;
      sepc_d    = flowTarget;
      pending_d = irqPulse;
    end else if (sel == TRET) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RPC;
      sepc_q    <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sepc_q    <= sepc_d;
      pending_q <= pending_d;
      ack_q     <= trapEntry;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;
  assign link    = (ju || jr) && !busy && !trapEntry;
  assign pclink  = pcSeq;
  assign sepc    = sepc_q;
  assign in_trap = (state_q == HANDLER);
  assign irq_ack = ack_q;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Self-checking bench for pc_trap_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_trap_unit;

  localparam int IB  = 4;
  localparam int RPC = 0;
  localparam int TV  = 'h40;
  localparam int IS  = 2;

  logic       clock = 1'b0;
  logic       reset, busy, interrupt, branch, eflag, ju, jr, tret;
  logic [7:0] imm, rs1_val;
  logic [7:0] pc, pc_next, pclink, sepc;
  logic       link, in_trap, irq_ack;

  pc_trap_unit #(
    .NBITS       (8),
    .INSTR_BYTES (IB),
    .RESET_PC    (RPC),
    .TRAP_VEC    (TV),
    .IRQ_SYNC    (IS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .busy      (busy),
    .interrupt (interrupt),
    .branch    (branch),
    .eflag     (eflag),
    .ju        (ju),
    .jr        (jr),
    .tret      (tret),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .pc        (pc),
    .pc_next   (pc_next),
    .link      (link),
    .pclink    (pclink),
    .sepc      (sepc),
    .in_trap   (in_trap),
    .irq_ack   (irq_ack)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: architectural values plus a list of edge indices at which
  // a captured interrupt becomes pending.
  logic [7:0] mPc, mSepc;
  logic       mInTrap, mPending, mAck, prevIn;
  int         edgeIdx = 0;
  int         setAt[$];

  function automatic logic [7:0] flowTarget();
    logic [7:0] sum;
    if (jr) begin
      sum = rs1_val + imm;
      return {sum[7:1], 1'b0};
    end
    if (ju || (branch && eflag)) return mPc + imm;
    return mPc + 8'(IB);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    reset = 0; busy = 0; branch = 0; eflag = 0; ju = 0; jr = 0; tret = 0;
    imm = 8'h00; rs1_val = 8'h00;
  endtask

  task automatic modelEdge();
    logic       pulse, entry;
    logic [7:0] tgt;
    edgeIdx++;
    if (reset) begin
      mPc = 8'(RPC); mSepc = 8'h00; mInTrap = 0; mPending = 0; mAck = 0;
      setAt.delete();
      prevIn = 0;
    end else begin
      pulse = 0;
      if (setAt.size() > 0 && setAt[0] == edgeIdx) begin
        pulse = 1;
        void'(setAt.pop_front());
      end
      entry = !busy && !mInTrap && mPending;
      tgt   = flowTarget();
      if (busy) begin
        mAck = 0;
        mPending = mPending | pulse;
      end else if (entry) begin
        mSepc = tgt; mPc = 8'(TV); mInTrap = 1; mPending = pulse; mAck = 1;
      end else begin
        mAck = 0;
        mPending = mPending | pulse;
        if (mInTrap && tret) begin
          mPc = mSepc; mInTrap = 0;
        end else begin
          mPc = tgt;
        end
      end
      if (interrupt && !prevIn) setAt.push_back(edgeIdx + IS);
      prevIn = interrupt;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance, check registers.
  task automatic applyStimulus();
    logic       entry, expLink;
    logic [7:0] expNext;
    @(negedge clock);
    #1;
    entry = !busy && !mInTrap && mPending;
    if (reset)                 expNext = 8'(RPC);
    else if (busy)             expNext = mPc;
    else if (entry)            expNext = 8'(TV);
    else if (mInTrap && tret)  expNext = mSepc;
    else                       expNext = flowTarget();
    expLink = (ju || jr) && !busy && !entry;
    checkOutput("pc_next", pc_next, expNext);
    checkOutput("link", {7'b0, link}, {7'b0, expLink});
    checkOutput("pclink", pclink, mPc + 8'(IB));
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("pc", pc, mPc);
    checkOutput("sepc", sepc, mSepc);
    checkOutput("in_trap", {7'b0, in_trap}, {7'b0, mInTrap});
    checkOutput("irq_ack", {7'b0, irq_ack}, {7'b0, mAck});
  endtask

  task automatic jumpTo(input logic [7:0] target);
    setIdle(); jr = 1; rs1_val = target;
    applyStimulus();
    setIdle();
  endtask

  initial begin
    mPc = 0; mSepc = 0; mInTrap = 0; mPending = 0; mAck = 0; prevIn = 0;
    setIdle();
    interrupt = 0;

    // Reset then free-running sequential fetch.
    reset = 1;
    applyStimulus();
    checkOutput("reset_pc", pc, 8'h00);
    checkOutput("reset_in_trap", {7'b0, in_trap}, 8'h00);
    reset = 0;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("seq_pc", pc, 8'h0C);

    // Taken and not-taken branch, then wrap-around.
    jumpTo(8'h10);
    branch = 1; eflag = 1; imm = 8'hF8;
    applyStimulus();
    checkOutput("br_taken", pc, 8'h08);
    jumpTo(8'h10);
    branch = 1; eflag = 0; imm = 8'hF8;
    applyStimulus();
    checkOutput("br_not_taken", pc, 8'h14);
    jumpTo(8'hFC);
    applyStimulus();
    checkOutput("wrap", pc, 8'h00);

    // JALR stalled by busy, then released.
    jumpTo(8'h20);
    jr = 1; rs1_val = 8'h31; imm = 8'h02; busy = 1;
    applyStimulus();
    checkOutput("busy_hold", pc, 8'h20);
    busy = 0;
    applyStimulus();
    checkOutput("jalr_pc", pc, 8'h32);
    setIdle();

    // Interrupt entry from sequential flow and return.
    jumpTo(8'h08);
    interrupt = 1;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("pre_entry_in_trap", {7'b0, in_trap}, 8'h00);
    applyStimulus();
    checkOutput("entry_pc", pc, 8'h40);
    checkOutput("entry_sepc", sepc, 8'h18);
    checkOutput("entry_ack", {7'b0, irq_ack}, 8'h01);
    interrupt = 0;
    applyStimulus();
    checkOutput("ack_once", {7'b0, irq_ack}, 8'h00);
    tret = 1;
    applyStimulus();
    checkOutput("tret_pc", pc, 8'h18);
    checkOutput("tret_in_trap", {7'b0, in_trap}, 8'h00);
    tret = 0;

    // Second interrupt while in the handler is deferred until after return.
    interrupt = 1;
    for (int i = 0; i < 4; i++) applyStimulus();
    interrupt = 0;
    applyStimulus();
    interrupt = 1;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("no_nest", {7'b0, in_trap}, 8'h01);
    tret = 1;
    applyStimulus();
    tret = 0;
    checkOutput("ret_to_sepc", pc, mSepc);
    applyStimulus();
    checkOutput("reenter_pc", pc, 8'h40);
    interrupt = 0;
    tret = 1;
    applyStimulus();
    tret = 0;

    // Pending interrupt held off by busy, taken on first free cycle.
    interrupt = 1;
    applyStimulus();
    busy = 1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("busy_no_entry", {7'b0, in_trap}, 8'h00);
    interrupt = 0;
    busy = 0;
    applyStimulus();
    checkOutput("busy_release_entry", pc, 8'h40);

    // Reset inside the handler with another interrupt pending.
    interrupt = 1;
    for (int i = 0; i < 4; i++) applyStimulus();
    interrupt = 0;
    reset = 1;
    applyStimulus();
    reset = 0;
    checkOutput("reset_handler_pc", pc, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("pending_dropped", {7'b0, in_trap}, 8'h00);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 99) < 2);
      busy    = ($urandom_range(0, 99) < 20);
      branch  = ($urandom_range(0, 99) < 25);
      eflag   = $urandom_range(0, 1) == 1;
      ju      = ($urandom_range(0, 99) < 10);
      jr      = ($urandom_range(0, 99) < 10);
      tret    = ($urandom_range(0, 99) < 15);
      imm     = 8'($urandom);
      rs1_val = 8'($urandom);
      if ($urandom_range(0, 99) < 12) interrupt = ~interrupt;
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
